// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - ID/EX, EX/MEM, MEM/WB control registers with hazard stall and ecall halt sequencing
// Load-use and ecall-operand hazards stall IF/ID and bubble EX; an accepted halting ecall drains, then halts.
module control_pipeline #(
   parameter int REG_ADDR_W   = 5,
   parameter int ECALL_REG    = 17,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic                  id_mem_read,
   input  logic                  id_mem_to_reg,
   input  logic                  id_mem_write,
   input  logic                  id_alu_src,
   input  logic                  id_write_enable,
   input  logic                  id_pc_to_reg,
   input  logic                  id_is_ecall,
   input  logic [1:0]            id_alu_op,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic                  halt_cond,
   output logic                  stall,
   output logic                  ex_mem_read,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_write,
   output logic                  ex_alu_src,
   output logic                  ex_write_enable,
   output logic                  ex_pc_to_reg,
   output logic [1:0]            ex_alu_op,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_mem_read,
   output logic                  mem_mem_to_reg,
   output logic                  mem_mem_write,
   output logic                  mem_write_enable,
   output logic                  mem_pc_to_reg,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_mem_to_reg,
   output logic                  wb_write_enable,
   output logic                  wb_pc_to_reg,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  is_halted
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [REG_ADDR_W-1:0] ECALL_RD  = REG_ADDR_W'(ECALL_REG);
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DRAIN_CYCLES);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   typedef struct packed {
      logic                  mem_read;
      logic                  mem_to_reg;
      logic                  mem_write;
      logic                  alu_src;
      logic                  write_enable;
      logic                  pc_to_reg;
      logic [1:0]            alu_op;
      logic [REG_ADDR_W-1:0] rd;
   } ex_ctl_t;

   state_t                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  halted_q;
   ex_ctl_t               ex_q, ex_d;
   logic                  mem_mem_read_q, mem_mem_to_reg_q, mem_mem_write_q;
   logic                  mem_write_enable_q, mem_pc_to_reg_q;
   logic [REG_ADDR_W-1:0] mem_rd_q;
   logic                  wb_mem_to_reg_q, wb_write_enable_q, wb_pc_to_reg_q;
   logic [REG_ADDR_W-1:0] wb_rd_q;

   logic load_use, ecall_haz, hazard, halt_accept;

   always_comb begin
      load_use = (state_q == RUN) && id_valid && ex_q.mem_read && (ex_q.rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));
      // The ecall reads x[ECALL_REG] in ID; only a pending ALU write in EX or a load in MEM can't be forwarded.
      ecall_haz = id_valid && id_is_ecall &&
                  ((ex_q.write_enable && (ex_q.rd == ECALL_RD)) ||
                   (mem_mem_read_q && (mem_rd_q == ECALL_RD)));
      hazard      = load_use || ecall_haz;
      halt_accept = (state_q == RUN) && id_valid && id_is_ecall && !hazard && halt_cond;
      stall       = (state_q == RUN) ? hazard : 1'b1;

      ex_d = '0;
      if ((state_q == RUN) && id_valid && !id_is_ecall && !hazard) begin
         ex_d.mem_read     = id_mem_read;
         ex_d.mem_to_reg   = id_mem_to_reg;
         ex_d.mem_write    = id_mem_write;
         ex_d.alu_src      = id_alu_src;
         ex_d.write_enable = id_write_enable;
         ex_d.pc_to_reg    = id_pc_to_reg;
         ex_d.alu_op       = id_alu_op;
         ex_d.rd           = id_rd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q            <= RUN;
         cnt_q              <= '0;
         halted_q           <= 1'b0;
         ex_q               <= '0;
         mem_mem_read_q     <= 1'b0;
         mem_mem_to_reg_q   <= 1'b0;
         mem_mem_write_q    <= 1'b0;
         mem_write_enable_q <= 1'b0;
         mem_pc_to_reg_q    <= 1'b0;
         mem_rd_q           <= '0;
         wb_mem_to_reg_q    <= 1'b0;
         wb_write_enable_q  <= 1'b0;
         wb_pc_to_reg_q     <= 1'b0;
         wb_rd_q            <= '0;
      end else begin
         ex_q               <= ex_d;
         mem_mem_read_q     <= ex_q.mem_read;
         mem_mem_to_reg_q   <= ex_q.mem_to_reg;
         mem_mem_write_q    <= ex_q.mem_write;
         mem_write_enable_q <= ex_q.write_enable;
         mem_pc_to_reg_q    <= ex_q.pc_to_reg;
         mem_rd_q           <= ex_q.rd;
         wb_mem_to_reg_q    <= mem_mem_to_reg_q;
         wb_write_enable_q  <= mem_write_enable_q;
         wb_pc_to_reg_q     <= mem_pc_to_reg_q;
         wb_rd_q            <= mem_rd_q;
         case (state_q)
            RUN: begin
               if (halt_accept) begin
                  state_q <= DRAIN;
                  cnt_q   <= CNT_W'(1);
               end
            end
            DRAIN: begin
               if (cnt_q == CNT_LAST) begin
                  state_q  <= HALTED;
                  halted_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q  <= HALTED;
               halted_q <= 1'b1;
            end
         endcase
      end
   end

   assign ex_mem_read      = ex_q.mem_read;
   assign ex_mem_to_reg    = ex_q.mem_to_reg;
   assign ex_mem_write     = ex_q.mem_write;
   assign ex_alu_src       = ex_q.alu_src;
   assign ex_write_enable  = ex_q.write_enable;
   assign ex_pc_to_reg     = ex_q.pc_to_reg;
   assign ex_alu_op        = ex_q.alu_op;
   assign ex_rd            = ex_q.rd;
   assign mem_mem_read     = mem_mem_read_q;
   assign mem_mem_to_reg   = mem_mem_to_reg_q;
   assign mem_mem_write    = mem_mem_write_q;
   assign mem_write_enable = mem_write_enable_q;
   assign mem_pc_to_reg    = mem_pc_to_reg_q;
   assign mem_rd           = mem_rd_q;
   assign wb_mem_to_reg    = wb_mem_to_reg_q;
   assign wb_write_enable  = wb_write_enable_q;
   assign wb_pc_to_reg     = wb_pc_to_reg_q;
   assign wb_rd            = wb_rd_q;
   assign is_halted        = halted_q;

endmodule
